// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the push-button front end.
//   key_state_t      - classifier FSM states
//   KEY_SYNC_STAGES  - depth of the pin synchroniser
//   ms_to_cyc()      - converts a duration in ms to clock cycles at clk_hz
package key_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        PRESSED    = 3'd2,
        LONG_HELD  = 3'd3,
        DB_RELEASE = 3'd4
    } key_state_t;

    localparam int KEY_SYNC_STAGES = 2;

    // Divide first so large clock rates do not overflow 32 bits.
    function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: synchroniser for the raw active-low key pin.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   key_n  in  raw active-low pin (asynchronous)
//   key_s  out synchronised pressed level (1 = pressed), KEY_SYNC_STAGES cycles late
// The flops hold the pin polarity and reset to 1, so a reset always reads as
// "released" and a key held through reset is seen as a fresh press.
module key_sync
    import key_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_s
);

    logic [KEY_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[KEY_SYNC_STAGES-2:0], key_n};
        end
    end

    assign key_s = ~sync_q[KEY_SYNC_STAGES-1];

endmodule

// File: rtl/key_press_classifier.sv
// key_press_classifier: debounces one push-button and classifies presses.
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   key_n       in  raw button pin, active-low, may bounce
//   key_level   out debounced pressed level (1 = pressed)
//   key_short   out 1-cycle pulse on an accepted release before the long time
//   key_long    out 1-cycle pulse when the hold reaches LONG_MS (once per press)
//   key_repeat  out 1-cycle pulse every REPEAT_MS after key_long while held
// Raw edge to key_level takes 2 (sync) + DB_CYC (debounce) + 1 cycles.
module key_press_classifier
    import key_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_short,
    output logic key_long,
    output logic key_repeat
);

    localparam int unsigned DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
    localparam int unsigned RPT_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);

    localparam int DB_W   = $clog2(DB_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam int RPT_W  = (RPT_CYC > 0) ? $clog2(RPT_CYC + 1) : 1;

    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DB_CYC);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'((RPT_CYC > 0) ? RPT_CYC - 1 : 0);

    logic key_s;

    key_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .key_s (key_s)
    );

    key_state_t        state, state_nxt;
    logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [RPT_W-1:0]  rpt_cnt, rpt_cnt_nxt;
    // Set once key_long has fired for the current press; doubles as the
    // remembered origin (LONG_HELD vs PRESSED) while in DB_RELEASE.
    logic              long_done, long_done_nxt;
    logic              level_nxt, short_nxt, long_nxt, repeat_nxt;

    logic held, hold_hit, rpt_hit, db_done;

    always_comb begin
        // Hold/repeat timing runs in every debounced-pressed state, including
        // DB_RELEASE, so a release bounce never disturbs the long/repeat schedule.
        held     = (state == PRESSED) || (state == LONG_HELD) || (state == DB_RELEASE);
        hold_hit = held && !long_done && (hold_cnt == HOLD_LAST);
        rpt_hit  = (RPT_CYC > 0) && held && long_done && (rpt_cnt == RPT_LAST);
        db_done  = (db_cnt == DB_MAX);

        state_nxt     = state;
        db_cnt_nxt    = db_cnt;
        hold_cnt_nxt  = hold_cnt;
        rpt_cnt_nxt   = rpt_cnt;
        long_done_nxt = long_done;
        short_nxt     = 1'b0;
        long_nxt      = hold_hit;
        repeat_nxt    = rpt_hit;

        // The hold counter stops at LONG_CYC-1 and the repeat counter wraps,
        // so neither can produce a spurious event however long the key is held.
        if (held && !long_done) begin
            if (hold_hit) begin
                long_done_nxt = 1'b1;
                rpt_cnt_nxt   = '0;
            end else begin
                hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
        end
        if ((RPT_CYC > 0) && held && long_done) begin
            rpt_cnt_nxt = rpt_hit ? '0 : rpt_cnt + RPT_W'(1);
        end

        case (state)
            IDLE: begin
                if (key_s) begin
                    state_nxt  = DB_PRESS;
                    db_cnt_nxt = DB_ONE;
                end
            end
            DB_PRESS: begin
                if (db_done) begin
                    state_nxt     = PRESSED;
                    db_cnt_nxt    = '0;
                    hold_cnt_nxt  = '0;
                    long_done_nxt = 1'b0;
                end else if (!key_s) begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_ONE;
                end
            end
            PRESSED, LONG_HELD: begin
                if (!key_s) begin
                    state_nxt  = DB_RELEASE;
                    db_cnt_nxt = DB_ONE;
                end else if (hold_hit) begin
                    state_nxt = LONG_HELD;
                end
            end
            DB_RELEASE: begin
                if (db_done) begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                    // A long firing on this very cycle also cancels the short.
                    short_nxt  = !long_done && !hold_hit;
                end else if (key_s) begin
                    state_nxt  = long_done_nxt ? LONG_HELD : PRESSED;
                    db_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt + DB_ONE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                db_cnt_nxt = '0;
            end
        endcase

        level_nxt = (state_nxt == PRESSED) || (state_nxt == LONG_HELD) ||
                    (state_nxt == DB_RELEASE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            db_cnt     <= '0;
            hold_cnt   <= '0;
            rpt_cnt    <= '0;
            long_done  <= 1'b0;
            key_level  <= 1'b0;
            key_short  <= 1'b0;
            key_long   <= 1'b0;
            key_repeat <= 1'b0;
        end else begin
            state      <= state_nxt;
            db_cnt     <= db_cnt_nxt;
            hold_cnt   <= hold_cnt_nxt;
            rpt_cnt    <= rpt_cnt_nxt;
            long_done  <= long_done_nxt;
            key_level  <= level_nxt;
            key_short  <= short_nxt;
            key_long   <= long_nxt;
            key_repeat <= repeat_nxt;
        end
    end

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier at CLK_HZ=1000: DB=5, LONG=50, RPT=10 cycles.
// Two instances share the pin and reset; the second has auto-repeat disabled.
module tb_key_press_classifier;
    import key_pkg::*;

    localparam int DB_C   = 5;
    localparam int LONG_C = 50;
    localparam int RPT_C  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic key_n = 1'b1;

    logic lvl_a, sh_a, lg_a, rp_a;
    logic lvl_b, sh_b, lg_b, rp_b;
    logic [3:0] obs_main, obs_nr, exp_main, exp_nr;

    assign obs_main = {lvl_a, sh_a, lg_a, rp_a};
    assign obs_nr   = {lvl_b, sh_b, lg_b, rp_b};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    key_press_classifier #(.CLK_HZ(1000), .DEBOUNCE_MS(5), .LONG_MS(50), .REPEAT_MS(10)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n),
        .key_level(lvl_a), .key_short(sh_a), .key_long(lg_a), .key_repeat(rp_a)
    );

    key_press_classifier #(.CLK_HZ(1000), .DEBOUNCE_MS(5), .LONG_MS(50), .REPEAT_MS(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .key_n(key_n),
        .key_level(lvl_b), .key_short(sh_b), .key_long(lg_b), .key_repeat(rp_b)
    );

    // ---------------- reference model ----------------
    // Works on the sequence of synchronised levels: a level change is taken
    // once the opposite level has been seen DB_C cycles in a row, and becomes
    // visible on the following cycle. Events are times relative to acceptance.
    int   cyc = 0;
    logic kq[$];
    logic m_level;
    int   m_run;
    bit   m_pend;
    int   m_acc;
    bit   m_long_done;

    task automatic model_reset();
        kq          = '{1'b1, 1'b1};
        m_level     = 1'b0;
        m_run       = 0;
        m_pend      = 1'b0;
        m_acc       = 0;
        m_long_done = 1'b0;
        exp_main    = 4'b0;
        exp_nr      = 4'b0;
    endtask

    // Apply one pin value for one clock and advance the model; outputs are
    // sampled by the caller 1 time unit after the edge.
    task automatic drive(input logic kn);
        logic v;
        bit   s, l, r;
        int   age;
        key_n = kn;
        @(posedge clk);
        cyc++;
        v = ~kq[0];
        void'(kq.pop_front());
        kq.push_back(kn);
        s = 1'b0; l = 1'b0; r = 1'b0;
        if (m_level) begin
            age = cyc - m_acc;
            if (age == LONG_C) begin
                l = 1'b1;
                m_long_done = 1'b1;
            end else if (m_long_done && age > LONG_C && ((age - LONG_C) % RPT_C) == 0) begin
                r = 1'b1;
            end
        end
        if (m_pend) begin
            m_pend  = 1'b0;
            m_run   = 0;
            m_level = ~m_level;
            if (m_level) begin
                m_acc       = cyc;
                m_long_done = 1'b0;
            end else if (!m_long_done) begin
                s = 1'b1;
            end
        end else begin
            if (v != m_level) m_run++;
            else m_run = 0;
            if (m_run == DB_C) m_pend = 1'b1;
        end
        exp_main = {m_level, s, l, r};
        exp_nr   = {m_level, s, l, 1'b0};
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int t_level, t_long;
        key_n = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (obs_main !== 4'b0) $display("FAIL reset_outputs out=%b exp=0000", obs_main); else n_pass++;
        n_checks++; if (obs_nr !== 4'b0) $display("FAIL reset_outputs_norpt out=%b exp=0000", obs_nr); else n_pass++;
        model_reset();
        rst_n   = 1'b1;
        t_level = -1;
        t_long  = -1;
        for (int p = 0; p < 90; p++) begin
            drive(p < 70 ? 1'b0 : 1'b1);
            n_checks++; if (obs_main !== exp_main) $display("FAIL reset_seq p=%0d out=%b exp=%b", p, obs_main, exp_main); else n_pass++;
            n_checks++; if (obs_nr !== exp_nr) $display("FAIL reset_seq_norpt p=%0d out=%b exp=%b", p, obs_nr, exp_nr); else n_pass++;
            if (lvl_a && t_level < 0) t_level = p;
            if (lg_a && t_long < 0) t_long = p;
        end
        n_checks++; if (t_level + 1 != 8) $display("FAIL reset_level_latency got=%0d exp=8", t_level + 1); else n_pass++;
        n_checks++; if (t_long - t_level != LONG_C) $display("FAIL reset_long_delay got=%0d exp=%0d", t_long - t_level, LONG_C); else n_pass++;
    endtask

    task automatic test_bounce();
        int n_active = 0;
        for (int p = 0; p < 30; p++) begin
            drive((p >= 5 && p < 8) ? 1'b0 : 1'b1);
            n_checks++; if (obs_main !== exp_main) $display("FAIL bounce_seq p=%0d out=%b exp=%b", p, obs_main, exp_main); else n_pass++;
            n_checks++; if (obs_nr !== exp_nr) $display("FAIL bounce_seq_norpt p=%0d out=%b exp=%b", p, obs_nr, exp_nr); else n_pass++;
            if (obs_main != 4'b0 || obs_nr != 4'b0) n_active++;
        end
        n_checks++; if (n_active != 0) $display("FAIL bounce_quiet active_cycles=%0d exp=0", n_active); else n_pass++;
        n_checks++; if (dut.state !== IDLE) $display("FAIL bounce_idle state=%0d exp=%0d", dut.state, IDLE); else n_pass++;
    endtask

    task automatic test_short();
        int t_short = -1, n_short = 0, n_other = 0, n_high = 0;
        for (int p = 0; p < 40; p++) begin
            drive(p < 20 ? 1'b0 : 1'b1);
            n_checks++; if (obs_main !== exp_main) $display("FAIL short_seq p=%0d out=%b exp=%b", p, obs_main, exp_main); else n_pass++;
            n_checks++; if (obs_nr !== exp_nr) $display("FAIL short_seq_norpt p=%0d out=%b exp=%b", p, obs_nr, exp_nr); else n_pass++;
            if (sh_a) begin n_short++; t_short = p; end
            if (lg_a || rp_a) n_other++;
            if (lvl_a) n_high++;
        end
        n_checks++; if (n_short != 1) $display("FAIL short_count got=%0d exp=1", n_short); else n_pass++;
        n_checks++; if (t_short - 20 + 1 != 8) $display("FAIL short_latency got=%0d exp=8", t_short - 20 + 1); else n_pass++;
        n_checks++; if (n_other != 0 || n_high == 0) $display("FAIL short_other long_or_rpt=%0d level_cycles=%0d exp=0,>0", n_other, n_high); else n_pass++;
    endtask

    task automatic test_long_repeat();
        int t_level = -1, t_long = -1, t_rpt = -1, n_long = 0, n_rpt = 0, n_short = 0, n_rpt_nr = 0;
        for (int p = 0; p < 110; p++) begin
            drive(p < 85 ? 1'b0 : 1'b1);
            n_checks++; if (obs_main !== exp_main) $display("FAIL long_seq p=%0d out=%b exp=%b", p, obs_main, exp_main); else n_pass++;
            n_checks++; if (obs_nr !== exp_nr) $display("FAIL long_seq_norpt p=%0d out=%b exp=%b", p, obs_nr, exp_nr); else n_pass++;
            if (lvl_a && t_level < 0) t_level = p;
            if (lg_a) begin n_long++; t_long = p; end
            if (rp_a) begin n_rpt++; if (t_rpt < 0) t_rpt = p; end
            if (sh_a || sh_b) n_short++;
            if (rp_b) n_rpt_nr++;
        end
        n_checks++; if (n_long != 1) $display("FAIL long_count got=%0d exp=1", n_long); else n_pass++;
        n_checks++; if (t_long - t_level != LONG_C) $display("FAIL long_delay got=%0d exp=%0d", t_long - t_level, LONG_C); else n_pass++;
        n_checks++; if (t_rpt - t_level != LONG_C + RPT_C) $display("FAIL repeat_first got=%0d exp=%0d", t_rpt - t_level, LONG_C + RPT_C); else n_pass++;
        n_checks++; if (n_rpt != 3) $display("FAIL repeat_count got=%0d exp=3", n_rpt); else n_pass++;
        n_checks++; if (n_short != 0) $display("FAIL long_no_short got=%0d exp=0", n_short); else n_pass++;
        n_checks++; if (n_rpt_nr != 0) $display("FAIL norpt_no_repeat got=%0d exp=0", n_rpt_nr); else n_pass++;
    endtask

    task automatic test_release_bounce();
        int t_level = -1, t_long = -1, n_drop = 0, n_short = 0;
        for (int p = 0; p < 100; p++) begin
            drive((p < 37 || (p >= 39 && p < 80)) ? 1'b0 : 1'b1);
            n_checks++; if (obs_main !== exp_main) $display("FAIL rbounce_seq p=%0d out=%b exp=%b", p, obs_main, exp_main); else n_pass++;
            n_checks++; if (obs_nr !== exp_nr) $display("FAIL rbounce_seq_norpt p=%0d out=%b exp=%b", p, obs_nr, exp_nr); else n_pass++;
            if (lvl_a && t_level < 0) t_level = p;
            if (lg_a && t_long < 0) t_long = p;
            if (p > 7 && p < 80 && !lvl_a) n_drop++;
            if (sh_a) n_short++;
        end
        n_checks++; if (n_drop != 0) $display("FAIL rbounce_level_drop got=%0d exp=0", n_drop); else n_pass++;
        n_checks++; if (t_long - t_level != LONG_C) $display("FAIL rbounce_long_delay got=%0d exp=%0d", t_long - t_level, LONG_C); else n_pass++;
        n_checks++; if (n_short != 0) $display("FAIL rbounce_no_short got=%0d exp=0", n_short); else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        int n_long = 0, n_short = 0, t_level = -1;
        for (int p = 0; p < 48; p++) begin
            drive(1'b0);
            n_checks++; if (obs_main !== exp_main) $display("FAIL midrst_pre p=%0d out=%b exp=%b", p, obs_main, exp_main); else n_pass++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (obs_main !== 4'b0) $display("FAIL midrst_clear out=%b exp=0000", obs_main); else n_pass++;
        n_checks++; if (obs_nr !== 4'b0) $display("FAIL midrst_clear_norpt out=%b exp=0000", obs_nr); else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int p = 0; p < 60; p++) begin
            drive(p < 40 ? 1'b0 : 1'b1);
            n_checks++; if (obs_main !== exp_main) $display("FAIL midrst_post p=%0d out=%b exp=%b", p, obs_main, exp_main); else n_pass++;
            n_checks++; if (obs_nr !== exp_nr) $display("FAIL midrst_post_norpt p=%0d out=%b exp=%b", p, obs_nr, exp_nr); else n_pass++;
            if (lg_a) n_long++;
            if (sh_a) n_short++;
            if (lvl_a && t_level < 0) t_level = p;
        end
        n_checks++; if (n_long != 0) $display("FAIL midrst_no_long got=%0d exp=0", n_long); else n_pass++;
        n_checks++; if (t_level + 1 != 8) $display("FAIL midrst_fresh_debounce got=%0d exp=8", t_level + 1); else n_pass++;
        n_checks++; if (n_short != 1) $display("FAIL midrst_short got=%0d exp=1", n_short); else n_pass++;
    endtask

    task automatic test_random();
        int len;
        logic kn;
        for (int k = 0; k < 25; k++) begin
            len = $urandom_range(1, 90);
            for (int p = 0; p < len; p++) begin
                kn = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
                drive(kn);
                n_checks++; if (obs_main !== exp_main) $display("FAIL random_press k=%0d p=%0d out=%b exp=%b", k, p, obs_main, exp_main); else n_pass++;
                n_checks++; if (obs_nr !== exp_nr) $display("FAIL random_press_norpt k=%0d p=%0d out=%b exp=%b", k, p, obs_nr, exp_nr); else n_pass++;
            end
            len = $urandom_range(1, 30);
            for (int p = 0; p < len; p++) begin
                kn = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
                drive(kn);
                n_checks++; if (obs_main !== exp_main) $display("FAIL random_gap k=%0d p=%0d out=%b exp=%b", k, p, obs_main, exp_main); else n_pass++;
                n_checks++; if (obs_nr !== exp_nr) $display("FAIL random_gap_norpt k=%0d p=%0d out=%b exp=%b", k, p, obs_nr, exp_nr); else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_short();
        test_long_repeat();
        test_release_bounce();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
